// File: rtl/frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_pkg
// Brief    : Shared types and helpers for the N-frame ring buffer controller:
//            reader policy enum, gray/binary conversion, FRAME_CNT legality.
// Revision : 1.0 - initial release
// ============================================================================
package frame_buffer_pkg;

  // Reader policy: show every frame in order, or jump to the newest frame.
  typedef enum logic {
    FB_RD_FIFO   = 1'b0,
    FB_RD_LATEST = 1'b1
  } fb_rd_mode_e;

  // Smallest ring that keeps one write slot, one display slot and a spare.
  localparam int FRAME_CNT_MIN = 4;

  // Conversion helpers work on a fixed wide vector; callers zero-extend
  // their pointer in and slice the low bits back out.
  localparam int c_gray_max_w = 32;

  function automatic logic [c_gray_max_w-1:0] bin2gray(input logic [c_gray_max_w-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [c_gray_max_w-1:0] gray2bin(input logic [c_gray_max_w-1:0] gray);
    logic [c_gray_max_w-1:0] bin;
    bin[c_gray_max_w-1] = gray[c_gray_max_w-1];
    for (int i = c_gray_max_w - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Elaboration-time legality check for the slot count.
  function automatic bit frame_cnt_ok(input int frame_cnt);
    return (frame_cnt >= FRAME_CNT_MIN) && ((frame_cnt & (frame_cnt - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_gray_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module   : fb_gray_ptr_sync
// Brief    : Carries a free-running binary pointer across clock domains:
//            registered gray code in the source domain, SYNC_STAGES flops in
//            the destination domain, then conversion back to binary.
// Revision : 1.0 - initial release
// ============================================================================
module fb_gray_ptr_sync
  import frame_buffer_pkg::*;
#(
  parameter int PTR_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             src_clk,
  input  logic             src_rstn,
  input  logic [PTR_W-1:0] src_ptr,
  input  logic             dst_clk,
  input  logic             dst_rstn,
  output logic [PTR_W-1:0] dst_ptr
);

  logic [c_gray_max_w-1:0] w_src_gray_full;
  logic [c_gray_max_w-1:0] w_dst_bin_full;
  logic [PTR_W-1:0]        r_src_gray;
  (* async_reg = "true" *)
  logic [SYNC_STAGES-1:0][PTR_W-1:0] r_sync;
  logic                    w_unused_hi;

  assign w_src_gray_full = bin2gray(c_gray_max_w'(src_ptr));

  // Source-side gray register: only one bit changes per pointer step.
  always_ff @(posedge src_clk or negedge src_rstn) begin
    if (!src_rstn) begin
      r_src_gray <= '0;
    end else begin
      r_src_gray <= w_src_gray_full[PTR_W-1:0];
    end
  end

  // Destination-side synchroniser chain.
  always_ff @(posedge dst_clk or negedge dst_rstn) begin
    if (!dst_rstn) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= r_src_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_dst_bin_full = gray2bin(c_gray_max_w'(r_sync[SYNC_STAGES-1]));
  assign dst_ptr        = w_dst_bin_full[PTR_W-1:0];

  // Upper bits of the wide helpers are always zero here.
  assign w_unused_hi = ^{w_src_gray_full[c_gray_max_w-1:PTR_W], w_dst_bin_full[c_gray_max_w-1:PTR_W]};

endmodule
`default_nettype wire

// File: rtl/frame_buffer_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_ring_ctrl
// Brief    : N-frame ring buffer slot manager between a write DMA and a
//            display DMA in independent clock domains. Guarantees the write
//            slot never equals the display slot. FIFO or LATEST read policy.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buffer_ring_ctrl
  import frame_buffer_pkg::*;
#(
  parameter int          FRAME_CNT   = 4,
  parameter int          SYNC_STAGES = 2,
  parameter fb_rd_mode_e RD_MODE     = FB_RD_FIFO,
  parameter int          CNT_WID     = 16
) (
  input  logic                         wr_clk,
  input  logic                         wr_rstn,
  input  logic                         rd_clk,
  input  logic                         rd_rstn,
  input  logic                         wr_vsync,
  input  logic                         wr_frame_ok,
  input  logic                         rd_vsync,
  output logic [$clog2(FRAME_CNT)-1:0] wr_frame_idx,
  output logic                         wr_full,
  output logic [$clog2(FRAME_CNT)-1:0] wr_level,
  output logic [CNT_WID-1:0]           wr_drop_cnt,
  output logic [$clog2(FRAME_CNT)-1:0] rd_frame_idx,
  output logic                         rd_frame_valid,
  output logic [CNT_WID-1:0]           rd_repeat_cnt,
  output logic [CNT_WID-1:0]           rd_skip_cnt
);

  localparam int                 c_idx_w    = $clog2(FRAME_CNT);
  localparam int                 c_ptr_w    = c_idx_w + 1;
  localparam logic [c_ptr_w-1:0] c_full_lvl = c_ptr_w'(FRAME_CNT - 2);

  generate
    if (!frame_cnt_ok(FRAME_CNT)) begin : g_bad_frame_cnt
      $error("frame_buffer_ring_ctrl: FRAME_CNT=%0d must be a power of two >= %0d", FRAME_CNT, FRAME_CNT_MIN);
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync_stages
      $error("frame_buffer_ring_ctrl: SYNC_STAGES=%0d must be 2..4", SYNC_STAGES);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Write domain
  // --------------------------------------------------------------------------
  logic               r_wr_vs;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] w_wr_ptr_inc;
  logic [c_ptr_w-1:0] w_rd_ptr_sync;
  logic [c_ptr_w-1:0] w_diff_w;
  logic               w_frame_end;
  logic               w_room;
  logic               w_commit;
  logic               w_drop;

  // diff_w uses a stale read pointer, so it can only overestimate fullness.
  assign w_diff_w     = r_wr_ptr - w_rd_ptr_sync;
  assign w_wr_ptr_inc = r_wr_ptr + c_ptr_w'(1);
  assign w_frame_end  = r_wr_vs & ~wr_vsync;
  // Anything at or above the full level is refused, including a corrupted
  // diff after a lone domain reset, so the writer never overruns the reader.
  assign w_room       = (w_diff_w < c_full_lvl);
  assign w_commit     = w_frame_end & wr_frame_ok & w_room;
  assign w_drop       = w_frame_end & wr_frame_ok & ~w_room;

  // Frame-end detection, write pointer advance and drop accounting.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_wr_vs      <= 1'b0;
      r_wr_ptr     <= '0;
      wr_frame_idx <= '0;
      wr_drop_cnt  <= '0;
    end else begin
      r_wr_vs <= wr_vsync;
      if (w_commit) begin
        r_wr_ptr     <= w_wr_ptr_inc;
        wr_frame_idx <= w_wr_ptr_inc[c_idx_w-1:0];
      end
      if (w_drop && (wr_drop_cnt != '1)) begin
        wr_drop_cnt <= wr_drop_cnt + CNT_WID'(1);
      end
    end
  end

  // Occupancy status as seen from the write side, refreshed every cycle.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      wr_full  <= 1'b0;
      wr_level <= '0;
    end else begin
      wr_full  <= (w_diff_w == c_full_lvl);
      wr_level <= w_diff_w[c_idx_w-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Pointer crossings
  // --------------------------------------------------------------------------
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] w_wr_ptr_sync;

  fb_gray_ptr_sync #(
    .PTR_W       (c_ptr_w),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wr2rd_sync (
    .src_clk  (wr_clk),
    .src_rstn (wr_rstn),
    .src_ptr  (r_wr_ptr),
    .dst_clk  (rd_clk),
    .dst_rstn (rd_rstn),
    .dst_ptr  (w_wr_ptr_sync)
  );

  fb_gray_ptr_sync #(
    .PTR_W       (c_ptr_w),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rd2wr_sync (
    .src_clk  (rd_clk),
    .src_rstn (rd_rstn),
    .src_ptr  (r_rd_ptr),
    .dst_clk  (wr_clk),
    .dst_rstn (wr_rstn),
    .dst_ptr  (w_rd_ptr_sync)
  );

  // --------------------------------------------------------------------------
  // Read domain
  // --------------------------------------------------------------------------
  (* async_reg = "true" *)
  logic [SYNC_STAGES-1:0] r_rd_vs_sync;
  logic                   r_rd_vs_d;
  logic                   w_rd_edge;
  logic                   w_rd_empty;
  logic                   w_rd_adv;
  logic [c_ptr_w-1:0]     w_rd_ptr_adv;
  logic [c_ptr_w-1:0]     w_rd_ptr_nxt;
  logic [c_ptr_w-1:0]     w_rd_idx_ptr;
  logic [c_ptr_w-1:0]     w_skip_inc;
  logic [CNT_WID:0]       w_skip_sum;

  // Synchronise the asynchronous display vsync and keep one delayed copy.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_rd_vs_sync <= '0;
      r_rd_vs_d    <= 1'b0;
    end else begin
      r_rd_vs_sync <= {r_rd_vs_sync[SYNC_STAGES-2:0], rd_vsync};
      r_rd_vs_d    <= r_rd_vs_sync[SYNC_STAGES-1];
    end
  end

  assign w_rd_edge  = r_rd_vs_sync[SYNC_STAGES-1] & ~r_rd_vs_d;
  assign w_rd_empty = (r_rd_ptr == w_wr_ptr_sync);
  assign w_rd_adv   = w_rd_edge & ~w_rd_empty;

  generate
    if (RD_MODE == FB_RD_LATEST) begin : g_rd_latest
      logic [c_ptr_w-1:0] w_diff_r;
      // Jump straight to the newest committed frame; frames in between are skipped.
      assign w_diff_r     = w_wr_ptr_sync - r_rd_ptr;
      assign w_rd_ptr_adv = w_wr_ptr_sync;
      assign w_skip_inc   = w_diff_r - c_ptr_w'(1);
    end else begin : g_rd_fifo
      assign w_rd_ptr_adv = r_rd_ptr + c_ptr_w'(1);
      assign w_skip_inc   = '0;
    end
  endgenerate

  assign w_rd_ptr_nxt = w_rd_adv ? w_rd_ptr_adv : r_rd_ptr;
  // Display slot trails the read pointer by one.
  assign w_rd_idx_ptr = w_rd_ptr_nxt - c_ptr_w'(1);
  assign w_skip_sum   = {1'b0, rd_skip_cnt} + (CNT_WID + 1)'(w_skip_inc);

  // Read pointer, display slot and validity flag.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_rd_ptr       <= '0;
      rd_frame_idx   <= c_idx_w'(FRAME_CNT - 1);
      rd_frame_valid <= 1'b0;
    end else begin
      r_rd_ptr     <= w_rd_ptr_nxt;
      rd_frame_idx <= w_rd_idx_ptr[c_idx_w-1:0];
      if (w_rd_adv) begin
        rd_frame_valid <= 1'b1;
      end
    end
  end

  // Saturating repeat (empty vsync) and skip statistics.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      rd_repeat_cnt <= '0;
      rd_skip_cnt   <= '0;
    end else begin
      if (w_rd_edge && w_rd_empty && (rd_repeat_cnt != '1)) begin
        rd_repeat_cnt <= rd_repeat_cnt + CNT_WID'(1);
      end
      if (w_rd_adv) begin
        rd_skip_cnt <= w_skip_sum[CNT_WID] ? '1 : w_skip_sum[CNT_WID-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_ring_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_frame_buffer_ring_ctrl
// Brief    : Self-checking bench: FIFO instance driven from a vector table
//            with an in-order slot scoreboard, a LATEST instance exercised by
//            hand-written sequences, then a random async phase with a
//            slot-collision monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_ring_ctrl;
  import frame_buffer_pkg::*;

  localparam int FC = 4;
  localparam int IW = 2;
  localparam int CW = 16;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic wr_rstn = 1'b0;
  logic rd_rstn = 1'b0;
  logic wr_vsync = 1'b0;
  logic wr_frame_ok = 1'b1;
  logic rd_vsync_f = 1'b0;
  logic rd_vsync_l = 1'b0;

  logic [IW-1:0] f_wr_frame_idx, f_wr_level, f_rd_frame_idx;
  logic          f_wr_full, f_rd_frame_valid;
  logic [CW-1:0] f_wr_drop_cnt, f_rd_repeat_cnt, f_rd_skip_cnt;
  logic [IW-1:0] l_wr_frame_idx, l_wr_level, l_rd_frame_idx;
  logic          l_wr_full, l_rd_frame_valid;
  logic [CW-1:0] l_wr_drop_cnt, l_rd_repeat_cnt, l_rd_skip_cnt;

  // 148.5 MHz write clock, 100 MHz read clock
  always #3.367 wr_clk = ~wr_clk;
  always #5.0   rd_clk = ~rd_clk;

  frame_buffer_ring_ctrl #(
    .FRAME_CNT(FC), .SYNC_STAGES(2), .RD_MODE(FB_RD_FIFO), .CNT_WID(CW)
  ) u_fifo (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .rd_clk(rd_clk), .rd_rstn(rd_rstn),
    .wr_vsync(wr_vsync), .wr_frame_ok(wr_frame_ok), .rd_vsync(rd_vsync_f),
    .wr_frame_idx(f_wr_frame_idx), .wr_full(f_wr_full), .wr_level(f_wr_level),
    .wr_drop_cnt(f_wr_drop_cnt), .rd_frame_idx(f_rd_frame_idx),
    .rd_frame_valid(f_rd_frame_valid), .rd_repeat_cnt(f_rd_repeat_cnt),
    .rd_skip_cnt(f_rd_skip_cnt)
  );

  frame_buffer_ring_ctrl #(
    .FRAME_CNT(FC), .SYNC_STAGES(2), .RD_MODE(FB_RD_LATEST), .CNT_WID(CW)
  ) u_latest (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .rd_clk(rd_clk), .rd_rstn(rd_rstn),
    .wr_vsync(wr_vsync), .wr_frame_ok(wr_frame_ok), .rd_vsync(rd_vsync_l),
    .wr_frame_idx(l_wr_frame_idx), .wr_full(l_wr_full), .wr_level(l_wr_level),
    .wr_drop_cnt(l_wr_drop_cnt), .rd_frame_idx(l_rd_frame_idx),
    .rd_frame_valid(l_rd_frame_valid), .rd_repeat_cnt(l_rd_repeat_cnt),
    .rd_skip_cnt(l_rd_skip_cnt)
  );

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  typedef enum int {OP_RD, OP_WR_OK, OP_WR_ABORT} op_e;
  typedef struct {
    op_e op;
    int  wr_idx;
    int  level;
    int  full;
    int  drop;
    int  rd_idx;
    int  valid;
    int  rep;
  } vec_t;

  vec_t vecs[$];
  int   sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic settle();
    repeat (10) @(negedge rd_clk);
    repeat (4) @(negedge wr_clk);
  endtask

  task automatic do_reset();
    wr_rstn = 1'b0;
    rd_rstn = 1'b0;
    wr_vsync = 1'b0;
    wr_frame_ok = 1'b1;
    rd_vsync_f = 1'b0;
    rd_vsync_l = 1'b0;
    repeat (4) @(negedge rd_clk);
    @(negedge wr_clk);
    wr_rstn = 1'b1;
    @(negedge rd_clk);
    rd_rstn = 1'b1;
    settle();
  endtask

  // One write frame; the falling edge of wr_vsync carries the ok flag.
  task automatic wr_frame(input bit ok);
    @(negedge wr_clk);
    wr_vsync = 1'b1;
    wr_frame_ok = ok;
    repeat (3) @(negedge wr_clk);
    wr_vsync = 1'b0;
    repeat (3) @(negedge wr_clk);
    wr_frame_ok = 1'b1;
  endtask

  // Display vsync pulse; mask bit 0 drives the FIFO instance, bit 1 the LATEST one.
  task automatic rd_pulse(input logic [1:0] mask);
    @(negedge rd_clk);
    rd_vsync_f = mask[0];
    rd_vsync_l = mask[1];
    repeat (6) @(negedge rd_clk);
    rd_vsync_f = 1'b0;
    rd_vsync_l = 1'b0;
    repeat (6) @(negedge rd_clk);
  endtask

  // Slot-collision monitor for the random phase.
  always @(negedge wr_clk) begin
    if (mon_en) begin
      if (f_rd_frame_valid) begin
        checks++;
        if (f_wr_frame_idx == f_rd_frame_idx) begin
          failures++;
          $display("FAIL collision_fifo: wr_idx=%0d rd_idx=%0d must differ", f_wr_frame_idx, f_rd_frame_idx);
        end
      end
      if (l_rd_frame_valid) begin
        checks++;
        if (l_wr_frame_idx == l_rd_frame_idx) begin
          failures++;
          $display("FAIL collision_latest: wr_idx=%0d rd_idx=%0d must differ", l_wr_frame_idx, l_rd_frame_idx);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached limit 1000000 ns", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev_wr_idx;
    int exp_slot;
    logic [IW-1:0] rd_before;

    // op, wr_idx, level, full, drop, rd_idx, valid, repeat  (FIFO instance)
    vecs.push_back('{OP_RD,       0, 0, 0, 0, 3, 0, 1});
    vecs.push_back('{OP_WR_OK,    1, 1, 0, 0, 3, 0, 1});
    vecs.push_back('{OP_WR_OK,    2, 2, 1, 0, 3, 0, 1});
    vecs.push_back('{OP_WR_OK,    2, 2, 1, 1, 3, 0, 1});
    vecs.push_back('{OP_RD,       2, 1, 0, 1, 0, 1, 1});
    vecs.push_back('{OP_RD,       2, 0, 0, 1, 1, 1, 1});
    vecs.push_back('{OP_RD,       2, 0, 0, 1, 1, 1, 2});
    vecs.push_back('{OP_WR_ABORT, 2, 0, 0, 1, 1, 1, 2});
    vecs.push_back('{OP_WR_OK,    3, 1, 0, 1, 1, 1, 2});
    vecs.push_back('{OP_RD,       3, 0, 0, 1, 2, 1, 2});
    vecs.push_back('{OP_WR_OK,    0, 1, 0, 1, 2, 1, 2});
    vecs.push_back('{OP_RD,       0, 0, 0, 1, 3, 1, 2});
    vecs.push_back('{OP_WR_OK,    1, 1, 0, 1, 3, 1, 2});
    vecs.push_back('{OP_RD,       1, 0, 0, 1, 0, 1, 2});
    vecs.push_back('{OP_WR_OK,    2, 1, 0, 1, 0, 1, 2});
    vecs.push_back('{OP_RD,       2, 0, 0, 1, 1, 1, 2});
    vecs.push_back('{OP_WR_OK,    3, 1, 0, 1, 1, 1, 2});
    vecs.push_back('{OP_RD,       3, 0, 0, 1, 2, 1, 2});
    vecs.push_back('{OP_WR_OK,    0, 1, 0, 1, 2, 1, 2});
    vecs.push_back('{OP_RD,       0, 0, 0, 1, 3, 1, 2});

    // ---------------- reset state ----------------
    do_reset();
    check("rst_f_wr_idx",  32'(f_wr_frame_idx),   0);
    check("rst_f_rd_idx",  32'(f_rd_frame_idx),   3);
    check("rst_f_valid",   32'(f_rd_frame_valid), 0);
    check("rst_f_level",   32'(f_wr_level),       0);
    check("rst_f_full",    32'(f_wr_full),        0);
    check("rst_f_drop",    32'(f_wr_drop_cnt),    0);
    check("rst_f_repeat",  32'(f_rd_repeat_cnt),  0);
    check("rst_f_skip",    32'(f_rd_skip_cnt),    0);
    check("rst_l_rd_idx",  32'(l_rd_frame_idx),   3);
    check("rst_l_skip",    32'(l_rd_skip_cnt),    0);

    // ---------------- table-driven FIFO sequence ----------------
    prev_wr_idx = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      rd_before = f_rd_frame_idx;
      case (vecs[i].op)
        OP_RD:       rd_pulse(2'b01);
        OP_WR_OK: begin
          wr_frame(1'b1);
          if (vecs[i].wr_idx != prev_wr_idx) sb_q.push_back(prev_wr_idx);
        end
        default:     wr_frame(1'b0);
      endcase
      settle();
      if (f_rd_frame_idx != rd_before) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL v%0d_sb_underflow: rd_idx changed to %0d with no committed frame queued", i, f_rd_frame_idx);
        end else begin
          exp_slot = sb_q.pop_front();
          check($sformatf("v%0d_sb_order", i), 32'(f_rd_frame_idx), exp_slot);
        end
      end
      check($sformatf("v%0d_wr_idx", i), 32'(f_wr_frame_idx),   vecs[i].wr_idx);
      check($sformatf("v%0d_level", i),  32'(f_wr_level),       vecs[i].level);
      check($sformatf("v%0d_full", i),   32'(f_wr_full),        vecs[i].full);
      check($sformatf("v%0d_drop", i),   32'(f_wr_drop_cnt),    vecs[i].drop);
      check($sformatf("v%0d_rd_idx", i), 32'(f_rd_frame_idx),   vecs[i].rd_idx);
      check($sformatf("v%0d_valid", i),  32'(f_rd_frame_valid), vecs[i].valid);
      check($sformatf("v%0d_repeat", i), 32'(f_rd_repeat_cnt),  vecs[i].rep);
      check($sformatf("v%0d_skip", i),   32'(f_rd_skip_cnt),    0);
      prev_wr_idx = vecs[i].wr_idx;
    end
    check("sb_leftover", 32'(sb_q.size()), 0);

    // ---------------- LATEST mode sequences ----------------
    do_reset();
    wr_frame(1'b1);
    wr_frame(1'b1);
    settle();
    rd_pulse(2'b10);
    settle();
    check("lat1_rd_idx",  32'(l_rd_frame_idx),   1);
    check("lat1_skip",    32'(l_rd_skip_cnt),    1);
    check("lat1_valid",   32'(l_rd_frame_valid), 1);
    check("lat1_level",   32'(l_wr_level),       0);
    check("lat1_full",    32'(l_wr_full),        0);
    check("lat1_repeat",  32'(l_rd_repeat_cnt),  0);
    check("lat1_f_level", 32'(f_wr_level),       2);
    check("lat1_f_full",  32'(f_wr_full),        1);
    check("lat1_f_rdidx", 32'(f_rd_frame_idx),   3);

    wr_frame(1'b1);
    settle();
    rd_pulse(2'b10);
    settle();
    check("lat2_rd_idx", 32'(l_rd_frame_idx), 2);
    check("lat2_skip",   32'(l_rd_skip_cnt),  1);
    check("lat2_wr_idx", 32'(l_wr_frame_idx), 3);
    check("lat2_f_drop", 32'(f_wr_drop_cnt),  1);
    check("lat2_f_widx", 32'(f_wr_frame_idx), 2);

    rd_pulse(2'b10);
    settle();
    check("lat3_repeat", 32'(l_rd_repeat_cnt), 1);
    check("lat3_rd_idx", 32'(l_rd_frame_idx),  2);

    wr_frame(1'b1);
    wr_frame(1'b1);
    settle();
    check("lat4_level", 32'(l_wr_level), 2);
    rd_pulse(2'b10);
    settle();
    check("lat4_rd_idx", 32'(l_rd_frame_idx), 0);
    check("lat4_skip",   32'(l_rd_skip_cnt),  2);
    check("lat4_f_drop", 32'(f_wr_drop_cnt),  3);

    // ---------------- random async phase with aborts ----------------
    do_reset();
    mon_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          bit            ok;
          logic [IW-1:0] idx_b;
          logic [CW-1:0] drop_b;
          repeat ($urandom_range(2, 25)) @(negedge wr_clk);
          ok = ($urandom_range(0, 3) != 0);
          idx_b = f_wr_frame_idx;
          drop_b = f_wr_drop_cnt;
          wr_frame(ok);
          if (!ok) begin
            check($sformatf("abort%0d_wr_idx", k), 32'(f_wr_frame_idx), int'(idx_b));
            check($sformatf("abort%0d_drop", k),   32'(f_wr_drop_cnt),  int'(drop_b));
          end
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(3, 30)) @(negedge rd_clk);
          rd_pulse(2'b11);
        end
      end
    join
    settle();
    mon_en = 1'b0;
    repeat (4) rd_pulse(2'b11);
    settle();
    check("drain_f_level", 32'(f_wr_level),       0);
    check("drain_f_full",  32'(f_wr_full),        0);
    check("drain_l_level", 32'(l_wr_level),       0);
    check("drain_f_valid", 32'(f_rd_frame_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
